// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects request lines into IF, gates them with IE and IME,
// and runs a REQ/ACK handshake with the CPU to dispatch the highest-priority pending source.
// IF (FF0F) and IE (FFFF) are memory-mapped on a shared tri-state data bus.
module int_ctrl #(
  parameter int unsigned NSRC = 5
) (
  input  logic        boga1mhz,
  input  logic        nreset2,
  input  logic [15:0] a,
  inout  tri   [7:0]  d,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        int_vblank,
  input  logic        int_stat,
  input  logic        int_timer,
  input  logic        int_serial,
  input  logic        int_jp,
  input  logic        ime_set,
  input  logic        ime_clr,
  input  logic        int_ack,
  output logic        irq,
  output logic [7:0]  vector,
  output logic        wake
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  // Registered state
  logic [NSRC-1:0] r_req_prev;
  logic            r_armed;
  logic [NSRC-1:0] r_if;
  logic [7:0]      r_ie;
  logic            r_ime;
  logic [1:0]      r_state;
  logic [2:0]      r_idx;
  logic            r_irq;
  logic            r_wake;

  // Combinational signals
  logic [NSRC-1:0] w_req;
  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_pending;
  logic [NSRC-1:0] w_idx_mask;
  logic [NSRC-1:0] w_disp_mask;
  logic            w_hit_if;
  logic            w_hit_ie;
  logic            w_rd_en;
  logic [7:0]      w_rd_data;
  logic            w_ack;
  logic            w_still;
  logic            w_disp_valid;
  logic [2:0]      w_disp_idx;
  logic [2:0]      w_vec_idx;
  logic [NSRC-1:0] w_if_d;
  logic            w_ime_d;
  logic [1:0]      w_state_d;
  logic [2:0]      w_idx_d;

  // Lowest set bit wins; bit 0 (vblank) has the highest priority.
  function automatic logic [2:0] f_lowest(input logic [NSRC-1:0] v);
    logic [2:0] res;
    res = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) res = i[2:0];
    end
    return res;
  endfunction

  assign w_req     = {int_jp, int_serial, int_timer, int_stat, int_vblank};
  // r_armed suppresses the first cycle after reset so a line already high is not an edge.
  assign w_edge    = w_req & ~r_req_prev & {NSRC{r_armed}};
  assign w_pending = r_if & r_ie[NSRC-1:0];

  assign w_hit_if  = (a == ADDR_IF);
  assign w_hit_ie  = (a == ADDR_IE);
  assign w_rd_en   = cpu_rd && (w_hit_if || w_hit_ie);
  assign w_rd_data = w_hit_if ? {3'b111, r_if} : r_ie;
  assign d         = w_rd_en ? w_rd_data : 8'hzz;

  assign w_ack      = (r_state == ST_REQ) && int_ack;
  assign w_idx_mask = {{(NSRC-1){1'b0}}, 1'b1} << r_idx;
  // The latched source may have been cancelled by a write to IF or IE while waiting.
  assign w_still    = |(w_pending & w_idx_mask);

  // Resolve which source is actually dispatched when the CPU acknowledges
  always_comb begin
    w_disp_valid = 1'b1;
    w_disp_idx   = r_idx;
    if (!w_still) begin
      if (|w_pending) begin
        w_disp_idx = f_lowest(w_pending);
      end else begin
        w_disp_valid = 1'b0;
      end
    end
  end

  assign w_disp_mask = {{(NSRC-1){1'b0}}, 1'b1} << w_disp_idx;
  assign w_vec_idx   = w_ack ? w_disp_idx : r_idx;

  // Vector follows the dispatch choice combinationally; zero when nothing survives cancellation
  always_comb begin
    vector = 8'h00;
    if (r_state == ST_REQ) begin
      if (w_ack && !w_disp_valid) begin
        vector = 8'h00;
      end else begin
        vector = {2'b01, w_vec_idx, 3'b000};
      end
    end
  end

  // IF next state: CPU write, then acknowledge clear, then new edges override both
  always_comb begin
    w_if_d = r_if;
    if (cpu_wr && w_hit_if) begin
      w_if_d = d[NSRC-1:0];
    end
    if (w_ack && w_disp_valid) begin
      w_if_d = w_if_d & ~w_disp_mask;
    end
    w_if_d = w_if_d | w_edge;
  end

  // IME next state: EI only honoured in IDLE; DI and any acknowledge clear it
  always_comb begin
    w_ime_d = r_ime;
    if (ime_set && (r_state == ST_IDLE)) begin
      w_ime_d = 1'b1;
    end
    if (ime_clr || w_ack) begin
      w_ime_d = 1'b0;
    end
  end

  // Dispatch FSM next state and latched source index
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (r_ime && (|w_pending)) begin
          w_state_d = ST_REQ;
          w_idx_d   = f_lowest(w_pending);
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          w_state_d = ST_ACK;
          if (w_disp_valid) w_idx_d = w_disp_idx;
        end
      end
      ST_ACK: begin
        w_state_d = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge boga1mhz) begin
    if (!nreset2) begin
      r_req_prev <= '0;
      r_armed    <= 1'b0;
      r_if       <= '0;
      r_ie       <= 8'h00;
      r_ime      <= 1'b0;
      r_state    <= ST_IDLE;
      r_idx      <= 3'd0;
      r_irq      <= 1'b0;
      r_wake     <= 1'b0;
    end else begin
      r_req_prev <= w_req;
      r_armed    <= 1'b1;
      r_if       <= w_if_d;
      if (cpu_wr && w_hit_ie) begin
        r_ie <= d;
      end
      r_ime      <= w_ime_d;
      r_state    <= w_state_d;
      r_idx      <= w_idx_d;
      r_irq      <= (w_state_d == ST_REQ);
      r_wake     <= |w_pending;
    end
  end

  assign irq  = r_irq;
  assign wake = r_wake;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-low: boga1mhz is the clock and nreset2 is the reset; all state updates occur on the rising edge of boga1mhz.
REQ-002 SHALL have ports, one per line, as name  direction  width  meaning:
- boga1mhz  in  1  clock
- nreset2  in  1  synchronous active-low reset
- a  in  16  CPU address bus
- d  inout (tri)  8  CPU data bus
- cpu_wr  in  1  write strobe (level, one write per cycle)
- cpu_rd  in  1  read strobe
- int_vblank, int_stat, int_timer, int_serial, int_jp  in  1 each  request lines, sources 0..4 in that order
- ime_set  in  1  CPU EI executed
- ime_clr  in  1  CPU DI executed
- int_ack  in  1  CPU dispatch acknowledge, one-cycle pulse
- irq  out  1  dispatch request to CPU
- vector  out  8  dispatch target address
- wake  out  1  HALT/STOP wake indication
REQ-003 SHALL have one parameter, one per line: NSRC, default 5, number of request sources; only 5 is supported.

Function
REQ-004 SHALL register each request line every cycle and detect rising edges (prev 0, now 1); a level held high SHALL set its flag only once.
REQ-005 SHALL hold IF[4:0]; a detected edge on source n SHALL set IF[n] on the next clock edge.
REQ-006 SHALL decode FF0F as IF: a write with cpu_wr=1 and a=16'hFF0F loads IF[4:0]=d[4:0]; a read drives d={3'b111,IF}.
REQ-007 SHALL decode FFFF as IE: a write loads all 8 bits of IE; a read returns all 8 bits; only IE[4:0] gate interrupts.
REQ-008 SHALL drive d only while cpu_rd=1 and the address matches FF0F or FFFF; otherwise d SHALL be high-Z.
REQ-009 SHALL, when an edge on bit n and a FF0F write occur in the same cycle, set IF[n]=1 (edge wins over written 0).
REQ-010 SHALL hold IME: ime_set sets IME on the next edge; ime_clr clears it; ime_clr SHALL win when both are asserted.
REQ-011 SHALL drive pending=IF[4:0]&IE[4:0]; wake=|pending, registered, independent of IME.
REQ-012 SHALL implement the FSM IDLE -> REQ -> ACK -> IDLE:
- IDLE: irq=0; if IME=1 and pending!=0, latch idx=lowest set bit of pending (bit0 highest priority) and go to REQ.
- REQ: irq=1, vector=8'h40+8*idx; on int_ack go to ACK.
- ACK: irq=0; one cycle; return to IDLE.
REQ-013 SHALL, on int_ack in REQ, clear IF[idx] and IME on the same edge, provided IF[idx]&IE[idx] is still 1.
REQ-014 SHALL, if IF[idx] or IE[idx] was cleared while in REQ (cancellation), re-evaluate pending at int_ack: use the new lowest set bit if one exists, else drive vector=8'h00 for that cycle, clear IME, and clear no IF bit.
REQ-015 SHALL let an edge on source idx coincident with int_ack leave IF[idx]=1 (set wins over acknowledge clear).
REQ-016 SHALL ignore ime_set while in REQ or ACK; IME is re-enabled only after IDLE is reached.
REQ-017 SHALL update vector combinationally from the latched or re-evaluated idx; irq SHALL be a registered output.

Reset
REQ-018 SHALL, on a clock edge with nreset2=0, set IF=0, IE=8'h00, IME=0, FSM=IDLE, edge registers=0, irq=0, vector=8'h00, wake=0.
REQ-019 SHALL, when reset is asserted mid-dispatch (REQ or ACK), abandon the dispatch, drop irq on that edge, and ignore int_ack.
REQ-020 SHALL, if a request line is already high when reset is released, not treat it as an edge.

Verification
REQ-021 Sequence: IE=8'h04, ime_set, int_timer 0->1 -> IF=8'hE4 on read, irq=1 within 2 cycles, vector=8'h50; int_ack -> IF=8'hE0, IME=0, irq=0.
REQ-022 Sequence: IE=8'h1F, IME=1, int_serial and int_vblank rise in the same cycle -> vector=8'h40; after ack and EI -> vector=8'h58.
REQ-023 Sequence: IME=0, IE=8'h01, int_vblank rises -> irq stays 0, wake=1, FF0F reads 8'hE1.
REQ-024 Sequence: dispatch of timer in REQ, then write FFFF=8'h00 before int_ack -> vector=8'h00 at ack, IF[2] stays 1, IME=0.
REQ-025 Sequence: write FF0F=8'h00 in the same cycle as an int_jp edge -> IF[4]=1; an int_jp held high for 10 cycles after clearing IF -> no re-set.
REQ-026 Sequence: nreset2=0 for one cycle during REQ -> irq=0, IF=0, IE=0 after the edge; int_ack on the next cycle has no effect.
